// File: rtl/fetch_prefetch_if.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_if
// Instruction-memory request/response port between the fetch front end and
// the memory controller.
//   memInstFree   memory can accept a new request
//   memInstOutEn  one-cycle pulse, memInst valid
//   memInst       returned instruction word
//   instEn        request valid, held with instAddr until memInstOutEn
//   instAddr      request address
// Modports: master = fetch side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              memInstFree;
  logic              memInstOutEn;
  logic [INST_W-1:0] memInst;
  logic              instEn;
  logic [ADDR_W-1:0] instAddr;

  modport master (
    input  memInstFree, memInstOutEn, memInst,
    output instEn, instAddr
  );

  modport slave (
    output memInstFree, memInstOutEn, memInst,
    input  instEn, instAddr
  );
endinterface

// File: rtl/fetch_prefetch.sv
// ---------------------------------------------------------------------------
// fetch_prefetch
// Instruction-fetch front end with a QDEPTH-entry prefetch queue between the
// instruction memory port and the decoder. Keeps fetching sequential words
// while the decoder stalls, stops after a branch/jump word (bit 6 set) and
// restarts on enJump/enBranch (enJump wins).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   stall                 decoder cannot accept; DecEn/PC/inst held
//   enJump/JumpAddr       jump redirect
//   enBranch/BranchAddr   taken-branch redirect
//   DecEn/PC/inst         registered decoder outputs
//   mem                   memory port (fetch_prefetch_if.master)
// Optional feature macro: FETCH_BYPASS_EN -- an accepted response arriving
// with the queue empty and no stall goes straight to PC/inst (latency 1).
// ---------------------------------------------------------------------------
module fetch_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              enJump,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic              enBranch,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic              DecEn,
  output logic [ADDR_W-1:0] PC,
  output logic [INST_W-1:0] inst,
  fetch_prefetch_if.master  mem
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QFULL  = (PW+1)'(QDEPTH);
  localparam logic [PW:0] QEMPTY = (PW+1)'(0);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAITBJ = 2'd2} state_t;

  state_t              state_r, state_n;
  logic                inst_en_r, inst_en_n;
  logic [ADDR_W-1:0]   inst_addr_r, inst_addr_n;
  logic                drop_r, drop_n;
  logic                dec_en_r, dec_en_n;
  logic [ADDR_W-1:0]   pc_r, pc_n;
  logic [INST_W-1:0]   inst_r, inst_n;
  logic [ADDR_W-1:0]   q_pc_r   [QDEPTH];
  logic [INST_W-1:0]   q_inst_r [QDEPTH];
  logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [PW:0]         count_r, count_n;

  logic                redir_s, resp_s, accept_s, bypass_s, push_s, pop_s, issue_ok_s;
  logic [ADDR_W-1:0]   target_s;

  assign DecEn        = dec_en_r;
  assign PC           = pc_r;
  assign inst         = inst_r;
  assign mem.instEn   = inst_en_r;
  assign mem.instAddr = inst_addr_r;

  // Queue control: redirect, response acceptance, push/pop and next occupancy
  always_comb begin
    redir_s  = enJump | enBranch;
    target_s = enJump ? JumpAddr : BranchAddr;
    // In REQ exactly one request is outstanding; a pulse elsewhere is ignored
    resp_s   = mem.memInstOutEn && (state_r == REQ);
    // A response is discarded when it is the dropped one or a redirect hits it
    accept_s = resp_s && !drop_r && !redir_s;
`ifdef FETCH_BYPASS_EN
    bypass_s = accept_s && !stall && (count_r == QEMPTY);
`else
    bypass_s = 1'b0;
`endif
    push_s   = accept_s && !bypass_s;
    pop_s    = !redir_s && !stall && (count_r != QEMPTY);
    if (redir_s) begin
      count_n = QEMPTY;
    end else begin
      count_n = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    end
    // No request is outstanding when this is consulted, so occupancy alone decides
    issue_ok_s = mem.memInstFree && (count_n < QFULL);
  end

  // Fetch FSM next-state and request outputs
  always_comb begin
    state_n     = state_r;
    inst_en_n   = inst_en_r;
    inst_addr_n = inst_addr_r;
    drop_n      = drop_r;
    if (redir_s) begin
      inst_addr_n = target_s;
      inst_en_n   = 1'b0;
      if ((state_r == REQ) && !resp_s) begin
        // Old request still in flight: swallow its response, then fetch target
        drop_n  = 1'b1;
        state_n = REQ;
      end else begin
        drop_n  = 1'b0;
        state_n = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_ok_s) begin
            inst_en_n = 1'b1;
            state_n   = REQ;
          end else begin
            inst_en_n = 1'b0;
            state_n   = IDLE;
          end
        end
        REQ: begin
          if (!resp_s) begin
            state_n = REQ;
          end else if (drop_r) begin
            // Dropped response consumed; instAddr already holds the target
            drop_n = 1'b0;
            if (issue_ok_s) begin
              inst_en_n = 1'b1;
              state_n   = REQ;
            end else begin
              inst_en_n = 1'b0;
              state_n   = IDLE;
            end
          end else if (mem.memInst[6]) begin
            inst_en_n = 1'b0;
            state_n   = WAITBJ;
          end else begin
            inst_addr_n = inst_addr_r + ADDR_W'(32'd4);
            if (issue_ok_s) begin
              inst_en_n = 1'b1;
              state_n   = REQ;
            end else begin
              inst_en_n = 1'b0;
              state_n   = IDLE;
            end
          end
        end
        WAITBJ: begin
          inst_en_n = 1'b0;
          state_n   = WAITBJ;
        end
        default: begin
          inst_en_n = 1'b0;
          drop_n    = 1'b0;
          state_n   = IDLE;
        end
      endcase
    end
  end

  // Decoder-side output selection
  always_comb begin
    dec_en_n = dec_en_r;
    pc_n     = pc_r;
    inst_n   = inst_r;
    if (stall) begin
      dec_en_n = dec_en_r;
    end else if (redir_s) begin
      dec_en_n = 1'b0;
    end else if (bypass_s) begin
      dec_en_n = 1'b1;
      pc_n     = inst_addr_r;
      inst_n   = mem.memInst;
    end else if (pop_s) begin
      dec_en_n = 1'b1;
      pc_n     = q_pc_r[rd_ptr_r];
      inst_n   = q_inst_r[rd_ptr_r];
    end else begin
      dec_en_n = 1'b0;
    end
  end

  // FSM, request and decoder output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      inst_en_r   <= 1'b0;
      inst_addr_r <= RESET_PC;
      drop_r      <= 1'b0;
      dec_en_r    <= 1'b0;
      pc_r        <= '0;
      inst_r      <= '0;
    end else begin
      state_r     <= state_n;
      inst_en_r   <= inst_en_n;
      inst_addr_r <= inst_addr_n;
      drop_r      <= drop_n;
      dec_en_r    <= dec_en_n;
      pc_r        <= pc_n;
      inst_r      <= inst_n;
    end
  end

  // Prefetch queue pointers, occupancy and storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= QEMPTY;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_r[i]   <= '0;
        q_inst_r[i] <= '0;
      end
    end else begin
      count_r <= count_n;
      if (redir_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) begin
          q_pc_r[wr_ptr_r]   <= inst_addr_r;
          q_inst_r[wr_ptr_r] <= mem.memInst;
          wr_ptr_r           <= wr_ptr_r + PW'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch
// Directed bench for fetch_prefetch. A behavioural instruction memory answers
// requests after a programmable latency; expected {PC,inst} pairs are queued
// by the stimulus and a separate monitor pops and compares them whenever the
// DUT presents a new decoder word. Held outputs under stall are also checked.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst, stall, enJump, enBranch;
  logic [AW-1:0] JumpAddr, BranchAddr, PC;
  logic          DecEn;
  logic [IW-1:0] inst;

  fetch_prefetch_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  fetch_prefetch #(.ADDR_W(AW), .INST_W(IW), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .enJump(enJump), .JumpAddr(JumpAddr), .enBranch(enBranch), .BranchAddr(BranchAddr),
    .DecEn(DecEn), .PC(PC), .inst(inst), .mem(bus)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [63:0]   exp_q [$];
  logic [31:0]   req_log [$];
  int            mem_lat = 0;
  logic [31:0]   bja = 32'h30;
  logic [31:0]   bjb = 32'hFFFF_FFF0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == bja || a == bjb) ? 32'h0000_0063 : 32'h0000_0013;
  endfunction

  task automatic exp_push(input logic [31:0] pc);
    exp_q.push_back({pc, word_at(pc)});
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(nm, 72'(exp_q.size()), 72'd0);
  endtask

  task automatic redirect(input logic j, input logic [31:0] ja, input logic b, input logic [31:0] ba);
    @(posedge clk); #1;
    enJump = j; JumpAddr = ja; enBranch = b; BranchAddr = ba;
    @(posedge clk); #1;
    enJump = 1'b0; enBranch = 1'b0;
  endtask

  // Instruction memory: samples requests mid-cycle, answers after mem_lat+1 cycles
  initial begin : mem_model
    logic        s_en, s_out, s_rst, busy;
    logic [31:0] s_addr, maddr;
    int          cnt;
    busy = 1'b0; cnt = 0; maddr = 32'h0;
    bus.memInstFree = 1'b1; bus.memInstOutEn = 1'b0; bus.memInst = 32'h0;
    forever begin
      @(negedge clk);
      s_en = bus.instEn; s_addr = bus.instAddr; s_out = bus.memInstOutEn; s_rst = rst;
      @(posedge clk); #1;
      bus.memInstOutEn = 1'b0;
      if (s_rst) begin
        busy = 1'b0;
      end else if (busy) begin
        if (cnt == 0) begin
          bus.memInstOutEn = 1'b1;
          bus.memInst = word_at(maddr);
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (s_en && !s_out) begin
        busy = 1'b1; maddr = s_addr; cnt = mem_lat;
        req_log.push_back(s_addr);
      end
    end
  end

  // Monitor: scoreboard compare on each new decoder word, hold check under stall
  initial begin : monitor
    logic        p_stall, p_rst;
    logic [64:0] p_out;
    logic [63:0] e;
    p_stall = 1'b1; p_rst = 1'b1; p_out = '0;
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        if (p_stall) begin
          chk("stall_hold", 72'({DecEn, PC, inst}), 72'(p_out));
        end else if (DecEn) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dec_extra: got PC %0h inst %0h, required no decoder word", PC, inst);
          end else begin
            e = exp_q.pop_front();
            chk("dec_pc", 72'(PC), 72'(e[63:32]));
            chk("dec_inst", 72'(inst), 72'(e[31:0]));
          end
        end
      end
      p_stall = stall; p_rst = rst; p_out = {DecEn, PC, inst};
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          n, k, base;
    logic        hit;
    logic [31:0] v;
    rst = 1'b1; stall = 1'b0; enJump = 1'b0; enBranch = 1'b0;
    JumpAddr = 32'h0; BranchAddr = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_decen",  72'(DecEn), 72'd0);
    chk("rst_pc",     72'(PC), 72'd0);
    chk("rst_inst",   72'(inst), 72'd0);
    chk("rst_insten", 72'(bus.instEn), 72'd0);
    chk("rst_addr",   72'(bus.instAddr), 72'h0);
    for (int a = 0; a <= 32'h30; a += 4) exp_push(32'(a));
    @(posedge clk); #1 rst = 1'b0;
    hit = 1'b0;
    for (k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bus.instEn) begin hit = 1'b1; break; end
    end
    chk("first_req", 72'({hit, bus.instAddr}), {39'd0, 1'b1, 32'h0});

    // Latency from first response to decoder
    hit = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.memInstOutEn) begin hit = 1'b1; break; end
    end
    chk("first_resp_seen", 72'(hit), 72'd1);
`ifdef FETCH_BYPASS_EN
    @(negedge clk); chk("lat_t1", 72'({DecEn, PC}), {39'd0, 1'b1, 32'h0});
`else
    @(negedge clk); chk("lat_t1", 72'(DecEn), 72'd0);
    @(negedge clk); chk("lat_t2", 72'({DecEn, PC}), {39'd0, 1'b1, 32'h0});
`endif

    // Long stall: queue fills, fetching stops, outputs held
    hit = 1'b0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (DecEn && PC == 32'h8) begin hit = 1'b1; break; end
    end
    chk("reach_pc8", 72'(hit), 72'd1);
    @(posedge clk); #1 stall = 1'b1;
    n = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.memInstOutEn) n++;
    end
    chk("stall_accept_le_q", 72'(n <= QD), 72'd1);
    chk("stall_insten_off", 72'(bus.instEn), 72'd0);
    @(posedge clk); #1 stall = 1'b0;
    drain("drain_seq");
    repeat (5) @(negedge clk);
    v = req_log[req_log.size()-1];
    chk("bj_last_req", 72'(v), 72'h30);
    chk("bj_insten_off", 72'(bus.instEn), 72'd0);

    // Branch stop with a full queue, then jump+branch together (jump wins, flush)
    @(posedge clk); #1 rst = 1'b1; stall = 1'b1; bja = 32'h0C; bjb = 32'h88;
    req_log.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("full_req_count", 72'(req_log.size()), 72'd4);
    v = (req_log.size() >= 4) ? req_log[3] : 32'hDEAD_BEEF;
    chk("full_last_req", 72'(v), 72'h0C);
    chk("full_insten_off", 72'(bus.instEn), 72'd0);
    exp_push(32'h80); exp_push(32'h84); exp_push(32'h88);
    redirect(1'b1, 32'h80, 1'b1, 32'h40);
    @(negedge clk);
    chk("jump_target", 72'(bus.instAddr), 72'h80);
    repeat (15) @(negedge clk);
    @(posedge clk); #1 stall = 1'b0;
    drain("drain_jump");
    v = (req_log.size() >= 5) ? req_log[4] : 32'hDEAD_BEEF;
    chk("jump_req", 72'(v), 72'h80);

    // Branch while the 0x14 request is outstanding: its response is dropped
    mem_lat = 6; bja = 32'h44;
    base = req_log.size();
    exp_push(32'h10);
    redirect(1'b1, 32'h10, 1'b0, 32'h0);
    hit = 1'b0;
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      if (req_log.size() >= base + 2) begin hit = 1'b1; break; end
    end
    chk("req14_seen", 72'(hit), 72'd1);
    v = (req_log.size() >= base + 2) ? req_log[base+1] : 32'hDEAD_BEEF;
    chk("req14_addr", 72'(v), 72'h14);
    exp_push(32'h40); exp_push(32'h44);
    redirect(1'b0, 32'h0, 1'b1, 32'h40);
    drain("drain_drop");
    v = (req_log.size() >= base + 3) ? req_log[base+2] : 32'hDEAD_BEEF;
    chk("after_drop_req", 72'(v), 72'h40);

    // Reset in the middle of a request with three words queued
    mem_lat = 0;
    @(posedge clk); #1 stall = 1'b1;
    redirect(1'b1, 32'h100, 1'b0, 32'h0);
    n = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.memInstOutEn) n++;
      if (n == 3) break;
    end
    chk("mid_three_resp", 72'(n), 72'd3);
    @(negedge clk);
    chk("mid_req_active", 72'(bus.instEn), 72'd1);
    @(posedge clk); #1 rst = 1'b1; bja = 32'h08;
    @(posedge clk); #1 rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("mid_rst_decen",  72'(DecEn), 72'd0);
    chk("mid_rst_insten", 72'(bus.instEn), 72'd0);
    chk("mid_rst_addr",   72'(bus.instAddr), 72'h0);
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
    drain("drain_refetch");
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
